// File: rtl/md_pkg.sv
// -----------------------------------------------------------------------------
// md_pkg
// Shared definitions for the multiply/divide scheduler:
//   - md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU)
//   - scheduler state enum (IDLE, MUL, DIV, FIX)
//   - MD_ITER : iterations per operation (equals the operand width)
//   - MD_CNT_W: iteration counter width (2**MD_CNT_W > MD_ITER)
//   - MD_DZ_QUOT: quotient written to LO on divide by zero
//   - small decode helpers for the md_op field
// -----------------------------------------------------------------------------
package md_pkg;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_e;

  localparam logic [MD_ITER-1:0] MD_DZ_QUOT = '1;

  // mult and div treat operands as two's complement.
  function automatic logic op_is_signed(input logic [1:0] op);
    logic s;
    case (md_op_e'(op))
      MD_MULT, MD_DIV: s = 1'b1;
      default:         s = 1'b0;
    endcase
    return s;
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    logic d;
    case (md_op_e'(op))
      MD_DIV, MD_DIVU: d = 1'b1;
      default:         d = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/md_div_step.sv
// -----------------------------------------------------------------------------
// md_div_step
// One combinational step of unsigned restoring division.
// The partial remainder is shifted left with the next dividend bit brought in;
// if the divisor fits, it is subtracted and the quotient bit is 1.
// Ports:
//   rem       in  W  current partial remainder
//   divisor   in  W  divisor magnitude
//   dvd_bit   in  1  next dividend bit (MSB first)
//   rem_next  out W  updated partial remainder
//   q_bit     out 1  quotient bit produced by this step
// -----------------------------------------------------------------------------
module md_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] divisor,
  input  logic         dvd_bit,
  output logic [W-1:0] rem_next,
  output logic         q_bit
);

  logic [W:0] shifted;
  logic [W:0] trial;

  // W+1 bits: while rem < divisor the shifted value stays below 2*divisor,
  // so the difference always fits back into W bits when it is kept.
  assign shifted  = {rem, dvd_bit};
  assign q_bit    = (shifted >= {1'b0, divisor});
  assign trial    = shifted - {1'b0, divisor};
  assign rem_next = q_bit ? trial[W-1:0] : shifted[W-1:0];

endmodule

// File: rtl/md_sched.sv
// -----------------------------------------------------------------------------
// md_sched
// Multiply/divide scheduler for a 5-stage MIPS pipeline. Accepts
// mult/multu/div/divu from EX, runs an iterative one-bit-per-cycle engine,
// owns HI/LO, serves mthi/mtlo, and stalls the front end while a HI/LO user
// sits in ID and the engine is busy. cancel (WB exception flush) aborts any
// in-flight operation without touching HI/LO.
//
// Timing for an op accepted at edge k: edges k+1..k+32 iterate, edge k+33
// applies sign correction, writes HI/LO and raises done for one cycle.
//
// Build option: define FAST_MUL_EN to compute mult/multu with a single-cycle
// array multiplier (result and done at edge k+1, busy never set for them).
// Without it, multiplies use the same iterative timing as divides.
//
// Ports:
//   clk          in   1     clock, rising edge
//   rst          in   1     synchronous active-high reset
//   cancel       in   1     exception flush; aborts in-flight op
//   md_start     in   1     EX holds a mult/multu/div/divu
//   md_op        in   2     00 mult, 01 multu, 10 div, 11 divu
//   op_a         in   XLEN  rs operand
//   op_b         in   XLEN  rt operand
//   mthi         in   1     write HI from op_a
//   mtlo         in   1     write LO from op_a
//   id_hilo_use  in   1     ID holds a HI/LO user or md op
//   md_stall     out  1     freeze IF/ID, bubble into EX
//   busy         out  1     engine running
//   done         out  1     one-cycle pulse after HI/LO written by an op
//   hi           out  XLEN  HI register
//   lo           out  XLEN  LO register
// -----------------------------------------------------------------------------
module md_sched
  import md_pkg::*;
#(
  parameter int XLEN  = MD_ITER,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cancel,
  input  logic            md_start,
  input  logic [1:0]      md_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            mthi,
  input  logic            mtlo,
  input  logic            id_hilo_use,
  output logic            md_stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  DZ_QUOT  = {XLEN{MD_DZ_QUOT[0]}};

  md_state_e         state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  // Work registers. MUL: {acc_hi, acc_lo} is the running product with the
  // multiplier shifting out of acc_lo. DIV: acc_hi is the partial remainder,
  // acc_lo shifts the dividend out and the quotient in.
  logic [XLEN-1:0]   acc_hi_reg, acc_hi_next;
  logic [XLEN-1:0]   acc_lo_reg, acc_lo_next;
  logic [XLEN-1:0]   opnd_reg, opnd_next;   // multiplicand or divisor magnitude
  logic              is_div_reg, is_div_next;
  logic              neg_q_reg, neg_q_next; // negate product / quotient
  logic              neg_r_reg, neg_r_next; // negate remainder
  logic              dz_reg, dz_next;       // divisor was zero
  logic [XLEN-1:0]   hi_reg, hi_next;
  logic [XLEN-1:0]   lo_reg, lo_next;
  logic              done_reg, done_next;

  // Operand decode for the op being issued.
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;

  assign a_neg = op_is_signed(md_op) & op_a[XLEN-1];
  assign b_neg = op_is_signed(md_op) & op_b[XLEN-1];
  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned
  // magnitude, so the most negative value needs no special case.
  assign a_mag = a_neg ? -op_a : op_a;
  assign b_mag = b_neg ? -op_b : op_b;

  // Shift-add step: add the multiplicand when the multiplier LSB is set,
  // then shift the 65-bit {carry, product} right by one.
  logic [XLEN:0]     mul_sum;
  assign mul_sum = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, opnd_reg} : {(XLEN+1){1'b0}});

  logic [XLEN-1:0]   div_rem;
  logic              div_q;

  md_div_step #(.W(XLEN)) u_div_step (
    .rem      (acc_hi_reg),
    .divisor  (opnd_reg),
    .dvd_bit  (acc_lo_reg[XLEN-1]),
    .rem_next (div_rem),
    .q_bit    (div_q)
  );

  // Sign correction applied in FIX.
  logic [2*XLEN-1:0] prod_raw, prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix;

  assign prod_raw = {acc_hi_reg, acc_lo_reg};
  assign prod_fix = neg_q_reg ? -prod_raw : prod_raw;
  assign quot_fix = dz_reg ? DZ_QUOT : (neg_q_reg ? -acc_lo_reg : acc_lo_reg);
  // With a zero divisor the restoring steps shift the whole dividend
  // magnitude into the remainder, so re-applying the dividend sign leaves
  // exactly the original dividend in HI.
  assign rem_fix  = neg_r_reg ? -acc_hi_reg : acc_hi_reg;

`ifdef FAST_MUL_EN
  // Single-cycle multiply: operands are parked in acc_hi/acc_lo at issue and
  // the product is written on the following edge while the FSM stays IDLE.
  logic              fast_pend_reg, fast_pend_next;
  logic              fast_sgn_reg, fast_sgn_next;
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;

  assign fast_a    = {{XLEN{fast_sgn_reg & acc_hi_reg[XLEN-1]}}, acc_hi_reg};
  assign fast_b    = {{XLEN{fast_sgn_reg & acc_lo_reg[XLEN-1]}}, acc_lo_reg};
  assign fast_prod = fast_a * fast_b;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_hi_next = acc_hi_reg;
    acc_lo_next = acc_lo_reg;
    opnd_next   = opnd_reg;
    is_div_next = is_div_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    dz_next     = dz_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    done_next   = 1'b0;
`ifdef FAST_MUL_EN
    fast_pend_next = 1'b0;
    fast_sgn_next  = fast_sgn_reg;
`endif

    case (state_reg)
      ST_IDLE: begin
`ifdef FAST_MUL_EN
        if (fast_pend_reg && !cancel) begin
          hi_next   = fast_prod[2*XLEN-1:XLEN];
          lo_next   = fast_prod[XLEN-1:0];
          done_next = 1'b1;
        end
`endif
        // md_start wins over mthi/mtlo; a flushed instruction does nothing.
        if (md_start && !cancel) begin
          cnt_next    = '0;
          is_div_next = op_is_div(md_op);
          neg_q_next  = a_neg ^ b_neg;
          neg_r_next  = a_neg;
          dz_next     = (op_b == '0);
          if (op_is_div(md_op)) begin
            acc_hi_next = '0;
            acc_lo_next = a_mag;
            opnd_next   = b_mag;
            state_next  = ST_DIV;
          end else begin
`ifdef FAST_MUL_EN
            acc_hi_next    = op_a;
            acc_lo_next    = op_b;
            fast_sgn_next  = op_is_signed(md_op);
            fast_pend_next = 1'b1;
`else
            acc_hi_next = '0;
            acc_lo_next = b_mag;
            opnd_next   = a_mag;
            state_next  = ST_MUL;
`endif
          end
        end else if (!cancel) begin
          if (mthi) hi_next = op_a;
          if (mtlo) lo_next = op_a;
        end
      end

      ST_MUL: begin
        if (cancel) begin
          state_next = ST_IDLE;
        end else begin
          acc_hi_next = mul_sum[XLEN:1];
          acc_lo_next = {mul_sum[0], acc_lo_reg[XLEN-1:1]};
          cnt_next    = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_LAST) state_next = ST_FIX;
        end
      end

      ST_DIV: begin
        if (cancel) begin
          state_next = ST_IDLE;
        end else begin
          acc_hi_next = div_rem;
          acc_lo_next = {acc_lo_reg[XLEN-2:0], div_q};
          cnt_next    = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_LAST) state_next = ST_FIX;
        end
      end

      ST_FIX: begin
        state_next = ST_IDLE;
        if (!cancel) begin
          if (is_div_reg) begin
            hi_next = rem_fix;
            lo_next = quot_fix;
          end else begin
            hi_next = prod_fix[2*XLEN-1:XLEN];
            lo_next = prod_fix[XLEN-1:0];
          end
          done_next = 1'b1;
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      opnd_reg   <= '0;
      is_div_reg <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      dz_reg     <= 1'b0;
      hi_reg     <= '0;
      lo_reg     <= '0;
      done_reg   <= 1'b0;
`ifdef FAST_MUL_EN
      fast_pend_reg <= 1'b0;
      fast_sgn_reg  <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_hi_reg <= acc_hi_next;
      acc_lo_reg <= acc_lo_next;
      opnd_reg   <= opnd_next;
      is_div_reg <= is_div_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      dz_reg     <= dz_next;
      hi_reg     <= hi_next;
      lo_reg     <= lo_next;
      done_reg   <= done_next;
`ifdef FAST_MUL_EN
      fast_pend_reg <= fast_pend_next;
      fast_sgn_reg  <= fast_sgn_next;
`endif
    end
  end

  assign busy     = (state_reg != ST_IDLE);
  assign md_stall = busy & id_hilo_use;
  assign done     = done_reg;
  assign hi       = hi_reg;
  assign lo       = lo_reg;

endmodule

// File: tb/tb_md_sched.sv
// -----------------------------------------------------------------------------
// tb_md_sched
// Directed self-checking bench for md_sched (default build, iterative
// multiply). Expected values are hand-computed constants; latency and
// busy/stall windows follow the k / k+33 timeline of the scheduler.
// -----------------------------------------------------------------------------
module tb_md_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        cancel;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic        id_hilo_use;
  logic        md_stall;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  md_sched dut (
    .clk         (clk),
    .rst         (rst),
    .cancel      (cancel),
    .md_start    (md_start),
    .md_op       (md_op),
    .op_a        (op_a),
    .op_b        (op_b),
    .mthi        (mthi),
    .mtlo        (mtlo),
    .id_hilo_use (id_hilo_use),
    .md_stall    (md_stall),
    .busy        (busy),
    .done        (done),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clk = ~clk;

  // Decode is one-hot: md_start together with mthi/mtlo must never be driven.
  always @(posedge clk) begin
    if (rst !== 1'b1) begin
      assert (!(md_start && (mthi || mtlo))) else begin
        failures++;
        $error("FAIL illegal_decode observed md_start=%b mthi=%b mtlo=%b", md_start, mthi, mtlo);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op, follow it to done, and check timing, busy/stall and result.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string tag);
    int n;
    int busy_bad;
    int stall_bad;
    bit got;
    @(negedge clk);
    md_start = 1'b1;
    md_op    = op;
    op_a     = a;
    op_b     = b;
    @(negedge clk);
    md_start = 1'b0;
    op_a     = 32'h0;
    op_b     = 32'h0;
    n = 0; busy_bad = 0; stall_bad = 0; got = 1'b0;
    // n = number of edges after the issue edge k (sampled at the negedge).
    while (n < 40 && !got) begin
      if (done === 1'b1) begin
        got = 1'b1;
      end else begin
        if (busy !== ((n <= 32) ? 1'b1 : 1'b0)) busy_bad++;
        if (md_stall !== ((n <= 32) ? id_hilo_use : 1'b0)) stall_bad++;
        n++;
        @(negedge clk);
      end
    end
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h done_after=%0d [%s]", op, a, b, hi, lo, n + 1, tag);
    chk({tag, " done_edge"}, 64'(n), 64'd33);
    chk({tag, " busy_window"}, 64'(busy_bad), 64'd0);
    chk({tag, " stall_window"}, 64'(stall_bad), 64'd0);
    chk({tag, " busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, " stall_at_done"}, 64'(md_stall), 64'd0);
    chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    chk({tag, " done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int pulses;
    rst = 1'b1; cancel = 1'b0; md_start = 1'b0; md_op = 2'b00;
    op_a = 32'h0; op_b = 32'h0; mthi = 1'b0; mtlo = 1'b0; id_hilo_use = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset stall", 64'(md_stall), 64'd0);
    rst = 1'b0;
    id_hilo_use = 1'b0;

    // Multiplies.
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "mult_neg3x5");

    // Divides, including sign rules and the zero / overflow corners.
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg7by2");
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7byneg2");
    run_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, "divu_100by7");
    run_op(2'b11, 32'h0000_1234, 32'h0, 32'h0000_1234, 32'hFFFF_FFFF, "divu_by0");
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, "div_neg_by0");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_by_m1");

    // mthi / mtlo in IDLE.
    @(negedge clk);
    mthi = 1'b1; op_a = 32'h0000_AAAA;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; op_a = 32'h0000_5555;
    @(negedge clk);
    mtlo = 1'b0; op_a = 32'h0;
    $display("mthi/mtlo -> hi=%h lo=%h", hi, lo);
    chk("mthi hi", 64'(hi), 64'h0000_AAAA);
    chk("mtlo lo", 64'(lo), 64'h0000_5555);

    // Cancel mid-divide: flush sampled at edge k+11.
    md_start = 1'b1; md_op = 2'b11; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    md_start = 1'b0; op_a = 32'h0; op_b = 32'h0;
    repeat (10) @(negedge clk);
    chk("cancel busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    $display("cancel -> busy=%b hi=%h lo=%h", busy, hi, lo);
    chk("cancel busy_after", 64'(busy), 64'd0);
    chk("cancel hi_kept", 64'(hi), 64'h0000_AAAA);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("cancel no_done", 64'(pulses), 64'd0);
    chk("cancel hi_final", 64'(hi), 64'h0000_AAAA);
    chk("cancel lo_final", 64'(lo), 64'h0000_5555);

    // Cancel arriving together with md_start: op must not be accepted.
    md_start = 1'b1; cancel = 1'b1; md_op = 2'b01; op_a = 32'd3; op_b = 32'd3;
    @(negedge clk);
    md_start = 1'b0; cancel = 1'b0; op_a = 32'h0; op_b = 32'h0;
    $display("start+cancel -> busy=%b", busy);
    chk("start_cancel busy", 64'(busy), 64'd0);

    // HI/LO consumer held in ID across a running op.
    id_hilo_use = 1'b1;
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, "stall_multu");
    id_hilo_use = 1'b0;

    // Reset in the middle of an operation.
    md_start = 1'b1; md_op = 2'b00; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    md_start = 1'b0; op_a = 32'h0; op_b = 32'h0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    $display("mid-op reset -> busy=%b hi=%h lo=%h", busy, hi, lo);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst hi", 64'(hi), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    chk("midrst no_done", 64'(pulses), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/md_sched.md
Name: md_sched

Overview:
Multiply/divide scheduler for the 5-stage MIPS pipeline. Accepts mult/multu/div/divu issued from EX, sequences an iterative 32-step engine, and owns the HI/LO registers. Serves mthi/mtlo writes and holds the pipeline (md_stall) while a later HI/LO consumer or producer finds the engine busy. Honours the writeback-stage exception flush (cancel) by aborting in-flight work.

Parameters:
XLEN, 32, operand/HI/LO width; iteration count equals XLEN.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
cancel  in  1  exception flush (if_cancel); aborts in-flight op
md_start  in  1  EX holds mult/multu/div/divu this cycle
md_op  in  2  00 mult, 01 multu, 10 div, 11 divu
op_a  in  XLEN  rs operand (forwarded)
op_b  in  XLEN  rt operand (forwarded)
mthi  in  1  write HI from op_a
mtlo  in  1  write LO from op_a
id_hilo_use  in  1  ID holds mfhi/mflo/mthi/mtlo/md op
md_stall  out  1  freeze IF/ID, bubble into EX
busy  out  1  engine running
done  out  1  one-cycle pulse, HI/LO just updated by an op
hi  out  XLEN  HI register
lo  out  XLEN  LO register

Behaviour:
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0, md_stall=0, counter=0.
- Single clock and sync active-high reset; rst overrides all inputs, including mid-operation.
- States: IDLE, MUL, DIV, FIX.
- IDLE: md_start & ~cancel at edge k latches |operands|, sign flags, op, counter=0 -> MUL or DIV.
- Sign flags: mult/div use 2's-complement magnitudes; multu/divu use raw operands.
- MUL: shift-add, one bit per edge, edges k+1..k+32 -> FIX.
- DIV: restoring division, one quotient bit per edge, edges k+1..k+32 -> FIX.
- FIX at edge k+33: apply sign correction, write HI/LO, pulse done, -> IDLE.
- Result placement: mult → hi = product[63:32], lo = product[31:0].
- Result placement: div → lo = quotient, hi = remainder.
- Signed division: quotient negative iff operand signs differ; remainder takes the dividend's sign.
- Divide by zero (either op): lo = 0xFFFFFFFF, hi = dividend. No exception raised.
- Signed 0x80000000 / -1: lo = 0x80000000, hi = 0.
- busy = 1 after edge k through edge k+33 inclusive; falls with done.
- md_stall = busy & id_hilo_use (combinational). A consumer in ID in the cycle after done reads the new hi/lo.
- mthi/mtlo are honoured only in IDLE: hi or lo <= op_a at the next edge. While busy they are held by md_stall.
- md_start, mthi and mtlo asserted together is illegal (decode is one-hot). Bench asserts on it; RTL gives md_start priority.
- cancel in any non-IDLE state -> IDLE at the next edge, hi/lo unchanged, no done.
- cancel in the same cycle as md_start: the op is not accepted.
- cancel in the FIX cycle: the write is suppressed.
- md_start while busy cannot occur (stalled). If it does, it is ignored.

Optional Feature:
FAST_MUL_EN defined:
- mult/multu use a single-cycle 32x32 array product. The result is written at edge k+1 with a done pulse; busy never asserts for multiplies.
- The divide path is unchanged.
FAST_MUL_EN undefined:
- Iterative 34-edge multiply as above.

Decomposition:
- Shared package md_pkg: md_op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU), state enum, MD_ITER = 32, div-by-zero quotient constant.
- One sub-module, md_div_step: combinational restoring step. Inputs: partial remainder, divisor, next dividend bit. Outputs: new remainder and quotient bit.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF issued at edge 0 -> busy edges 1-33, done after edge 33, hi=0xFFFFFFFE, lo=0x00000001.
- mult -3 x 5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- divu 0x1234 / 0 -> lo=0xFFFFFFFF, hi=0x00001234.
- div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Set hi=0xAAAA via mthi, then start a div and assert cancel at edge 10 -> IDLE at edge 11, hi still 0xAAAA, no done.
- Hold id_hilo_use (mfhi) during a running op -> md_stall=1 every busy cycle, 0 in the cycle after done; that mfhi reads the new hi.
